// File: rtl/dcsk_msg_serializer.sv
// rtl/dcsk_msg_serializer.sv - queued parallel-to-serial message front end for the DCSK modulator
// Each message bit is held for SF enabled cycles; words stream back-to-back from a small FIFO.
module dcsk_msg_serializer #(
    parameter int MSG_WIDTH = 8,
    parameter int SF        = 16,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MSG_WIDTH-1:0] in_data,
    input  logic                 in_lsb_first,
    input  logic                 en,
    input  logic                 flush,
    output logic                 out_bit,
    output logic                 out_valid,
    output logic                 bit_start,
    output logic                 msg_last,
    output logic                 empty
);

    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam int BW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CHIP_MAX = CW'(SF - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(MSG_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q;
    logic [CW-1:0]        chip_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [MSG_WIDTH-1:0] shreg_q;
    logic                 lsb_first_q;

    logic [MSG_WIDTH:0]   mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;

    logic q_empty, q_full, push, end_of_word, load;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign q_empty     = (wr_ptr_q == rd_ptr_q);
    assign q_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready    = !q_full && !flush;
    assign push        = in_valid && in_ready;
    assign end_of_word = (state_q == SHIFT) && (chip_cnt_q == CHIP_MAX) && (bit_cnt_q == BIT_MAX);
    assign load        = !flush && en && !q_empty && ((state_q == IDLE) || end_of_word);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (load) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_lsb_first, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chip_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            lsb_first_q <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            chip_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (en) begin
            if (load) begin
                state_q                <= SHIFT;
                {lsb_first_q, shreg_q} <= mem_q[rd_ptr_q[AW-1:0]];
                chip_cnt_q             <= '0;
                bit_cnt_q              <= '0;
            end else if (end_of_word) begin
                state_q    <= IDLE;
                chip_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else if (state_q == SHIFT) begin
                if (chip_cnt_q == CHIP_MAX) begin
                    chip_cnt_q <= '0;
                    bit_cnt_q  <= bit_cnt_q + 1'b1;
                    shreg_q    <= lsb_first_q ? {1'b0, shreg_q[MSG_WIDTH-1:1]}
                                              : {shreg_q[MSG_WIDTH-2:0], 1'b0};
                end else begin
                    chip_cnt_q <= chip_cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign out_bit   = out_valid && (lsb_first_q ? shreg_q[0] : shreg_q[MSG_WIDTH-1]);
    assign bit_start = out_valid && (chip_cnt_q == '0);
    assign msg_last  = out_valid && (bit_cnt_q == BIT_MAX);
    assign empty     = (state_q == IDLE) && q_empty;

endmodule

// File: tb/tb_dcsk_msg_serializer.sv
// tb/tb_dcsk_msg_serializer.sv - randomized self-checking bench for dcsk_msg_serializer
// The reference model tracks words and a per-word enabled-cycle position, not shift registers.
module tb_dcsk_msg_serializer;

    localparam int W  = 8;
    localparam int SF = 4;
    localparam int D  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_lsb_first, en, flush;
    logic [W-1:0] in_data;
    logic         out_bit, out_valid, bit_start, msg_last, empty;

    dcsk_msg_serializer #(.MSG_WIDTH(W), .SF(SF), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_lsb_first(in_lsb_first), .en(en), .flush(flush),
        .out_bit(out_bit), .out_valid(out_valid), .bit_start(bit_start),
        .msg_last(msg_last), .empty(empty)
    );

    always #5 clk = ~clk;

    bit           m_busy, m_lsb, m_acc;
    logic [W-1:0] m_data;
    int           m_pos;
    logic [W:0]   m_q[$];

    int n_checks = 0, n_pass = 0;
    int vld_cnt, bs_cnt, last_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_pos  = 0;
    endtask

    task automatic model_step();
        m_acc = in_valid && (m_q.size() < D) && !flush;
        if (flush) begin
            model_reset();
        end else begin
            if (en) begin
                if (!m_busy || m_pos == W*SF-1) begin
                    if (m_q.size() > 0) begin
                        {m_lsb, m_data} = m_q.pop_front();
                        m_busy = 1;
                        m_pos  = 0;
                    end else begin
                        m_busy = 0;
                        m_pos  = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
            if (m_acc) m_q.push_back({in_lsb_first, in_data});
        end
    endtask

    task automatic compare_all();
        int b;
        int eb;
        b  = m_pos / SF;
        eb = m_busy ? int'(m_data[m_lsb ? b : W-1-b]) : 0;
        check("out_valid", out_valid, m_busy);
        check("out_bit",   out_bit,   eb);
        check("bit_start", bit_start, m_busy && (m_pos % SF == 0));
        check("msg_last",  msg_last,  m_busy && (b == W-1));
        check("empty",     empty,     !m_busy && (m_q.size() == 0));
        check("in_ready",  in_ready,  (m_q.size() < D) && !flush);
        vld_cnt  += out_valid;
        bs_cnt   += bit_start;
        last_cnt += msg_last;
    endtask

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit l, input bit e, input bit f);
        in_valid = v; in_data = d; in_lsb_first = l; en = e; flush = f;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 1, 0);
    endtask

    task automatic clr_cnt();
        vld_cnt = 0; bs_cnt = 0; last_cnt = 0;
    endtask

    initial begin
        logic [W-1:0] words [5];
        int k, guard;

        rst_n = 0; in_valid = 0; in_data = '0; in_lsb_first = 0; en = 0; flush = 0;
        model_reset();
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_empty", empty, 1);
        @(negedge clk);
        rst_n = 1;

        // single word 0xA5, MSB first
        clr_cnt();
        cyc(1, 8'hA5, 0, 1, 0);
        idle(40);
        check("a5_valid_cycles", vld_cnt, W*SF);
        check("a5_bit_starts", bs_cnt, W);
        check("a5_last_cycles", last_cnt, SF);
        check("a5_empty_after", empty, 1);

        // back-to-back LSB-first then MSB-first
        clr_cnt();
        cyc(1, 8'hA5, 1, 1, 0);
        cyc(1, 8'h3C, 0, 1, 0);
        idle(70);
        check("b2b_valid_cycles", vld_cnt, 2*W*SF);
        check("b2b_last_cycles", last_cnt, 2*SF);

        // queue full with in_valid held
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        k = 0; guard = 0;
        while (k < 5 && guard < 400) begin
            cyc(1, words[k], 0, 1, 0);
            if (m_acc) k++;
            guard++;
            if (guard == 3) check("full_accepted3", k, 3);
        end
        check("full_all_accepted", k, 5);
        idle(5*W*SF + 10);

        // en every other cycle, with a push landing on an en=0 cycle
        cyc(1, 8'hC3, 0, 1, 0);
        cyc(1, 8'h5A, 1, 0, 0);
        for (int i = 0; i < 2*W*SF*2 + 20; i++) cyc(0, '0, 0, i % 2, 0);

        // flush at bit 3 with two words queued
        cyc(1, 8'h96, 0, 1, 0);
        cyc(1, 8'h69, 0, 1, 0);
        cyc(1, 8'hF0, 1, 1, 0);
        guard = 0;
        while (!(m_busy && m_pos == 3*SF) && guard < 100) begin
            idle(1);
            guard++;
        end
        check("flush_reached_bit3", guard < 100, 1);
        cyc(1, 8'h77, 0, 1, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_empty", empty, 1);
        in_valid = 0; flush = 0; #1;
        check("flush_in_ready", in_ready, 1);
        clr_cnt();
        cyc(1, 8'hFF, 0, 1, 0);
        idle(40);
        check("ff_valid_cycles", vld_cnt, W*SF);

        // asynchronous reset mid-word
        cyc(1, 8'hB4, 0, 1, 0);
        idle(10);
        #2 rst_n = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_bit", out_bit, 0);
        check("arst_bit_start", bit_start, 0);
        check("arst_msg_last", msg_last, 0);
        check("arst_empty", empty, 1);
        check("arst_in_ready", in_ready, 1);
        model_reset();
        in_valid = 0; en = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        cyc(1, 8'h4D, 1, 1, 0);
        idle(40);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 1), W'($urandom), $urandom_range(0, 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
